// File: rtl/tpu_pkg.sv
// Shared TPU types: the 80-bit instruction word, opcode constants, the
// instruction-issue state encoding and the opcode legality check.
package tpu_pkg;

    typedef struct packed {
        logic [7:0]  op_code;
        logic [71:0] payload;
    } instr_type;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_LOAD_WEIGHT = 8'h08;
    localparam logic [7:0] OP_STORE       = 8'h10;
    localparam logic [7:0] OP_MATMUL      = 8'h20;
    localparam logic [7:0] OP_ACTIVATE    = 8'h30;
    localparam logic [7:0] OP_HALT        = 8'hFE;
    localparam logic [7:0] OP_SYNC        = 8'hFF;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SYNC_WAIT = 2'd1,
        HALTED    = 2'd2
    } issue_state_type;

    // True for every opcode the control unit knows how to execute.
    function automatic logic is_legal_op(input logic [7:0] op);
        case (op)
            OP_NOP, OP_LOAD_WEIGHT, OP_STORE, OP_MATMUL,
            OP_ACTIVATE, OP_HALT, OP_SYNC: is_legal_op = 1'b1;
            default:                       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_issue.sv
// Instruction issue stage: pops instructions from the head of instr_fifo and
// hands them to the control unit through a one-entry valid/ready register.
// SYNC and HALT are executed here and never forwarded.
// Optional feature: define INSTR_ISSUE_ILLEGAL_CHECK_EN to drop opcodes that
// fail tpu_pkg::is_legal_op() and raise the sticky illegal_op flag.
module instr_issue
    import tpu_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  instr_type            fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_next_en,
    output instr_type            instr_out,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 units_busy,
    input  logic                 resume,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] issued_cnt,
    output logic                 illegal_op
);

    issue_state_type state, next_state;
    logic [7:0]      op;
    logic            slot_free;
    logic            transfer;
    logic            pop;
    logic            load;
`ifdef INSTR_ISSUE_ILLEGAL_CHECK_EN
    logic            drop;
`endif

    assign op        = fifo_data.op_code;
    assign slot_free = !instr_valid || instr_ready;
    assign transfer  = instr_valid && instr_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= next_state;
    end

    // Next-state logic: pseudo-ops park the stage until their condition clears.
    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (!fifo_empty) begin
                    if (op == OP_SYNC)      next_state = SYNC_WAIT;
                    else if (op == OP_HALT) next_state = HALTED;
                end
            end
            SYNC_WAIT: if (!instr_valid && !units_busy) next_state = RUN;
            HALTED:    if (resume) next_state = RUN;
            default:   next_state = RUN;
        endcase
    end

    // Output logic: decide whether the head is popped and whether it is loaded.
    always_comb begin
        pop  = 1'b0;
        load = 1'b0;
`ifdef INSTR_ISSUE_ILLEGAL_CHECK_EN
        drop = 1'b0;
`endif
        if (state == RUN && !fifo_empty) begin
            if (op == OP_SYNC || op == OP_HALT) begin
                pop = 1'b1;
            end
`ifdef INSTR_ISSUE_ILLEGAL_CHECK_EN
            else if (!is_legal_op(op)) begin
                pop  = 1'b1;
                drop = 1'b1;
            end
`endif
            else if (slot_free) begin
                pop  = 1'b1;
                load = 1'b1;
            end
        end
    end

    // The pop strobe is held low while in reset so the FIFO is never drained then.
    assign fifo_next_en = pop && rst;
    assign halted       = (state == HALTED);

    // Output register and transfer counter; a load in the transfer cycle keeps valid high.
    // NOTE: instr_out is a single register, not a memory, so it is reset along with valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            if (load) begin
                instr_out   <= fifo_data;
                instr_valid <= 1'b1;
            end else if (transfer) begin
                instr_valid <= 1'b0;
            end
            if (transfer) issued_cnt <= issued_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef INSTR_ISSUE_ILLEGAL_CHECK_EN
    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      illegal_op <= 1'b0;
        else if (drop) illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: a queue stands in for instr_fifo, and all
// expected values are hand-derived cycle by cycle.
module tb_instr_issue;
    import tpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    instr_type   fifo_data;
    logic        fifo_empty;
    logic        fifo_next_en;
    instr_type   instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        units_busy;
    logic        resume;
    logic        halted;
    logic [31:0] issued_cnt;
    logic        illegal_op;

    instr_type   fifo_q[$];
    int          pop_count = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    localparam instr_type I_A  = 80'h08AA_0000_0000_0000_0001;
    localparam instr_type I_B  = 80'h2000_0000_0000_0000_00B0;
    localparam instr_type I_C  = 80'h0800_0000_0000_0000_00C0;
    localparam instr_type I_SY = 80'hFF00_0000_0000_0000_0000;
    localparam instr_type I_D  = 80'h2000_0000_0000_0000_00D0;
    localparam instr_type I_HL = 80'hFE00_0000_0000_0000_0000;
    localparam instr_type I_E  = 80'h2000_0000_0000_0000_00E0;
    localparam instr_type I_F  = 80'h7700_0000_0000_0000_00F0;
    localparam instr_type I_G  = 80'h0800_0000_0000_0000_0006;

    instr_issue #(.CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_next_en (fifo_next_en),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .units_busy   (units_busy),
        .resume       (resume),
        .halted       (halted),
        .issued_cnt   (issued_cnt),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? instr_type'('0) : fifo_q[0];
    endtask

    task automatic push(input instr_type i);
        fifo_q.push_back(i);
        refresh();
    endtask

    // Advance one cycle: honour the pop strobe seen at the edge, end at the next falling edge.
    task automatic tick();
        logic pop_now;
        @(posedge clk);
        pop_now = fifo_next_en;
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_count++;
            refresh();
        end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        instr_ready = 1'b0;
        units_busy  = 1'b0;
        resume      = 1'b0;
        refresh();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_valid",   80'(instr_valid),  80'd0);
        check("rst_out",     instr_out,         80'd0);
        check("rst_cnt",     80'(issued_cnt),   80'd0);
        check("rst_halted",  80'(halted),       80'd0);
        check("rst_illegal", 80'(illegal_op),   80'd0);
        check("rst_pop",     80'(fifo_next_en), 80'd0);
        rst = 1'b1;
        tick();
        tick();
        check("idle_pop",    80'(fifo_next_en), 80'd0);
        check("idle_popcnt", 80'(pop_count),    80'd0);

        // Single instruction, consumer ready
        instr_ready = 1'b1;
        push(I_A);
        #1;
        check("a_pop",    80'(fifo_next_en), 80'd1);
        check("a_nvalid", 80'(instr_valid),  80'd0);
        tick();
        check("a_valid",  80'(instr_valid),  80'd1);
        check("a_out",    instr_out,         I_A);
        check("a_popcnt", 80'(pop_count),    80'd1);
        tick();
        check("a_drain",  80'(instr_valid),  80'd0);
        check("a_cnt",    80'(issued_cnt),   80'd1);

        // Back-pressure, then back-to-back issue
        instr_ready = 1'b0;
        push(I_B);
        push(I_C);
        tick();
        check("bp_popcnt1", 80'(pop_count), 80'd1 + 80'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_out", instr_out,         I_B);
            check("bp_hold_val", 80'(instr_valid),  80'd1);
            check("bp_no_pop",   80'(fifo_next_en), 80'd0);
            tick();
        end
        check("bp_popcnt2", 80'(pop_count), 80'd2);
        instr_ready = 1'b1;
        #1;
        check("b2b_pop", 80'(fifo_next_en), 80'd1);
        tick();
        check("b2b_out",   instr_out,        I_C);
        check("b2b_valid", 80'(instr_valid), 80'd1);
        check("b2b_cnt",   80'(issued_cnt),  80'd2);
        tick();
        check("b2b_drain", 80'(instr_valid), 80'd0);
        check("b2b_cnt2",  80'(issued_cnt),  80'd3);

        // SYNC waits for idle units
        units_busy = 1'b1;
        push(I_SY);
        push(I_D);
        #1;
        check("sync_pop", 80'(fifo_next_en), 80'd1);
        tick();
        check("sync_popcnt", 80'(pop_count),    80'd4);
        check("sync_valid",  80'(instr_valid),  80'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sync_hold_pop", 80'(fifo_next_en), 80'd0);
            check("sync_hold_cnt", 80'(pop_count),    80'd4);
        end
        units_busy = 1'b0;
        tick();
        check("sync_exit_pop", 80'(fifo_next_en), 80'd1);
        check("sync_exit_val", 80'(instr_valid),  80'd0);
        tick();
        check("sync_d_valid", 80'(instr_valid), 80'd1);
        check("sync_d_out",   instr_out,        I_D);
        tick();
        check("sync_cnt", 80'(issued_cnt), 80'd4);

        // HALT until resume
        push(I_HL);
        push(I_E);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("halt_flag",   80'(halted),       80'd1);
            check("halt_no_pop", 80'(fifo_next_en), 80'd0);
            tick();
        end
        check("halt_popcnt", 80'(pop_count), 80'd6);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_halted", 80'(halted),       80'd0);
        check("resume_pop",    80'(fifo_next_en), 80'd1);
        tick();
        check("resume_valid", 80'(instr_valid), 80'd1);
        check("resume_out",   instr_out,        I_E);
        tick();
        check("resume_cnt", 80'(issued_cnt), 80'd5);

        // Unknown opcode 8'h77
        push(I_F);
        #1;
        check("ill_pop", 80'(fifo_next_en), 80'd1);
        tick();
        check("ill_popcnt", 80'(pop_count), 80'd8);
`ifdef INSTR_ISSUE_ILLEGAL_CHECK_EN
        check("ill_valid", 80'(instr_valid), 80'd0);
        check("ill_flag",  80'(illegal_op),  80'd1);
        tick();
        check("ill_cnt",    80'(issued_cnt), 80'd5);
        check("ill_sticky", 80'(illegal_op), 80'd1);
`else
        check("ill_valid", 80'(instr_valid), 80'd1);
        check("ill_out",   instr_out,        I_F);
        check("ill_flag",  80'(illegal_op),  80'd0);
        tick();
        check("ill_cnt",    80'(issued_cnt), 80'd6);
        check("ill_sticky", 80'(illegal_op), 80'd0);
`endif

        // Asynchronous reset while an instruction is held
        instr_ready = 1'b0;
        push(I_G);
        tick();
        check("mid_valid", 80'(instr_valid), 80'd1);
        check("mid_out",   instr_out,        I_G);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid",   80'(instr_valid), 80'd0);
        check("arst_out",     instr_out,        80'd0);
        check("arst_cnt",     80'(issued_cnt),  80'd0);
        check("arst_illegal", 80'(illegal_op),  80'd0);
        check("arst_halted",  80'(halted),      80'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_valid", 80'(instr_valid),  80'd0);
        check("post_pop",   80'(fifo_next_en), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
